id_stage_gen: RTL and testbench
===============================

ID_STAGE_GEN -- requirements
Module: id_stage_gen

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width; NFWD, default 3, forwarding channels (index 0 = nearest stage); LOAD_LAT, default 1, load-use stall cycles (1..7).
REQ-002 SHALL have ports: clk in 1, clock; rst in 1, asynchronous active-low reset; one clock, reset is asynchronous and active-low.
REQ-003 SHALL have ports: if_valid in 1, IF holds an instruction; if_inst in 32; if_pc4 in XLEN; id_ready out 1, ID accepts this cycle.
REQ-004 SHALL have ports: ex_ready in 1, downstream accepts; id_valid out 1; id_inst out 32; id_pc4 out XLEN.
REQ-005 SHALL have ports: flush in 1, redirect kill; rf_raddr_a, rf_raddr_b out 5; rf_rdata_a, rf_rdata_b in XLEN.
REQ-006 SHALL have ports: fwd_valid in NFWD; fwd_dest in 5*NFWD; fwd_data in XLEN*NFWD; ex_is_load in 1; ex_dest in 5.
REQ-007 SHALL have ports: id_opa, id_opb out XLEN, forwarded operands; id_stall out 1; id_br_eq out 1.

Function
REQ-008 SHALL hold one instruction in an IF/ID register (valid, inst, pc4); rf_raddr_a = inst[25:21], rf_raddr_b = inst[20:16], combinational from the register.
REQ-009 SHALL load IF/ID when id_ready=1: valid <= if_valid, inst/pc4 <= inputs; id_ready = !id_stall && (!valid || ex_ready).
REQ-010 SHALL keep IF/ID unchanged while id_ready=0.
REQ-011 SHALL drive id_valid = valid && !id_stall; a stall issues a bubble (id_valid=0), never a duplicate.
REQ-012 SHALL select each operand: address 0 -> 0; else lowest index i with fwd_valid[i] and fwd_dest[i]==address -> fwd_data[i]; else rf data.
REQ-013 SHALL detect load-use when valid, ex_is_load, ex_dest!=0, and ex_dest equals rs or rt.
REQ-014 SHALL implement FSM RUN/STALL: RUN->STALL on load-use with counter <= LOAD_LAT-1; STALL decrements each cycle; STALL->RUN when counter==0.
REQ-015 SHALL assert id_stall in the detection cycle and every STALL cycle, i.e. exactly LOAD_LAT cycles per load-use; no re-detection from the same load.
REQ-016 SHALL on flush clear valid next edge, force FSM to RUN, and take priority over stall and ex_ready; if_valid in the flush cycle is discarded.
REQ-017 SHALL treat inst==0 as NOP: it never triggers load-use.

Reset
REQ-018 SHALL on rst=0 asynchronously clear valid, inst, pc4, counter, FSM=RUN.
REQ-019 SHALL during reset output id_valid=0, id_stall=0, id_ready=0, id_br_eq=0; id_ready rises the cycle after release.
REQ-020 SHALL discard any stall in progress when reset is asserted mid-stall.

Configuration
REQ-021 SHALL, with ID_BRANCH_COMPARE_EN defined, drive id_br_eq = valid && (id_opa==id_opb), using forwarded operands and forced 0 while id_stall.
REQ-022 SHALL, without ID_BRANCH_COMPARE_EN, tie id_br_eq to 0 and omit the comparator.

Structure
REQ-023 SHALL place FSM state encoding, NOP constant, and rs/rt field positions in shared package id_pkg.
REQ-024 SHALL use one sub-module, id_fwd_sel (priority operand mux), instantiated once per operand.

Verification
REQ-025 SHALL test forward priority: rs=5, fwd_valid=3'b011, fwd_dest[0]=fwd_dest[1]=5, data 0xAAAA/0xBBBB -> id_opa=0xAAAA.
REQ-026 SHALL test $0 rule: rs=0, fwd_dest[0]=0 valid, data 0x1234 -> id_opa=0.
REQ-027 SHALL test load-use with LOAD_LAT=2, ex_is_load, ex_dest=7, rt=7 -> id_stall high exactly 2 cycles, id_valid=0, inst then issues once.
REQ-028 SHALL test backpressure: ex_ready=0 for 3 cycles -> id_ready=0, IF/ID held, no instruction lost or duplicated.
REQ-029 SHALL test flush during STALL -> valid=0 next cycle, FSM RUN, id_stall=0.
REQ-030 SHALL test ID_BRANCH_COMPARE_EN: opa=opb=0x10 via fwd channel 2 -> id_br_eq=1; macro undefined -> 0.

Source files
------------

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared definitions for the decode stage
//
// Purpose : FSM state encoding, NOP constant, register-field positions and
//           small field-extraction helpers used by id_stage_gen.
// Ports   : none (package).
package id_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } id_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int REG_AW = 5;   // register address width
    localparam int RS_LSB = 21;  // rs occupies inst[25:21]
    localparam int RT_LSB = 16;  // rt occupies inst[20:16]
    localparam int CNT_W  = 3;   // holds LOAD_LAT-1 for LOAD_LAT up to 7

    function automatic logic [REG_AW-1:0] rs_of(input logic [31:0] inst);
        return inst[RS_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] rt_of(input logic [31:0] inst);
        return inst[RT_LSB +: REG_AW];
    endfunction

endpackage

// File: rtl/id_fwd_sel.sv
// rtl/id_fwd_sel.sv - priority operand mux for one source register
//
// Purpose : selects an operand value: $0 reads as zero, otherwise the
//           lowest-indexed valid forwarding channel whose destination
//           matches wins, otherwise the register-file value is used.
// Ports   : addr       - source register address
//           fwd_valid  - per-channel valid (index 0 = nearest stage)
//           fwd_dest   - packed per-channel destination addresses
//           fwd_data   - packed per-channel result data
//           rf_data    - register-file read data for addr
//           data       - selected operand
module id_fwd_sel
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 3
) (
    input  logic [REG_AW-1:0]      addr,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [REG_AW*NFWD-1:0] fwd_dest,
    input  logic [XLEN*NFWD-1:0]   fwd_data,
    input  logic [XLEN-1:0]        rf_data,
    output logic [XLEN-1:0]        data
);

    always_comb begin
        data = rf_data;
        // Walk from the farthest channel to the nearest so the lowest
        // matching index is the last assignment and therefore wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_dest[i*REG_AW +: REG_AW] == addr)) begin
                data = fwd_data[i*XLEN +: XLEN];
            end
        end
        // $0 is hardwired zero no matter what a stage claims to write.
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_stage_gen.sv
// rtl/id_stage_gen.sv - decode stage: IF/ID register, forwarding, load-use stall
//
// Purpose : holds one instruction, reads/forwards its two source operands,
//           stalls LOAD_LAT cycles on a load-use hazard, honours flush and
//           downstream backpressure.
// Config  : define ID_BRANCH_COMPARE_EN to build the operand equality
//           comparator driving id_br_eq; otherwise id_br_eq is tied low.
// Ports   : clk, rst (async, active-low)
//           if_valid/if_inst/if_pc4 -> id_ready      : fetch handshake
//           id_valid/id_inst/id_pc4 -> ex_ready      : execute handshake
//           flush                                    : redirect kill
//           rf_raddr_a/b, rf_rdata_a/b               : register file reads
//           fwd_valid/fwd_dest/fwd_data              : forwarding channels
//           ex_is_load, ex_dest                      : load in execute
//           id_opa, id_opb, id_stall, id_br_eq       : decode results
module id_stage_gen
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NFWD     = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_inst,
    input  logic [XLEN-1:0]        if_pc4,
    output logic                   id_ready,
    input  logic                   ex_ready,
    output logic                   id_valid,
    output logic [31:0]            id_inst,
    output logic [XLEN-1:0]        id_pc4,
    input  logic                   flush,
    output logic [REG_AW-1:0]      rf_raddr_a,
    output logic [REG_AW-1:0]      rf_raddr_b,
    input  logic [XLEN-1:0]        rf_rdata_a,
    input  logic [XLEN-1:0]        rf_rdata_b,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [REG_AW*NFWD-1:0] fwd_dest,
    input  logic [XLEN*NFWD-1:0]   fwd_data,
    input  logic                   ex_is_load,
    input  logic [REG_AW-1:0]      ex_dest,
    output logic [XLEN-1:0]        id_opa,
    output logic [XLEN-1:0]        id_opb,
    output logic                   id_stall,
    output logic                   id_br_eq
);

    logic              valid_q;
    logic [31:0]       inst_q;
    logic [XLEN-1:0]   pc4_q;
    logic              rdy_q;     // low through reset and the release cycle
    logic              served_q;  // current instruction already paid its load-use stall
    id_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [REG_AW-1:0] rs, rt;
    logic              load_use;

    assign rs         = rs_of(inst_q);
    assign rt         = rt_of(inst_q);
    assign rf_raddr_a = rs;
    assign rf_raddr_b = rt;
    assign id_inst    = inst_q;
    assign id_pc4     = pc4_q;

    // The served flag blocks a second detection against the same load when
    // the stall ends while execute still presents it.
    assign load_use = (state_q == ST_RUN) && valid_q && !served_q &&
                      (inst_q != NOP_INST) && ex_is_load &&
                      (ex_dest != '0) && ((ex_dest == rs) || (ex_dest == rt));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state. The detection cycle is itself the first stall cycle,
    // so STALL covers the remaining LOAD_LAT-1 cycles; LOAD_LAT=1 never
    // leaves RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (load_use && (LOAD_LAT > 1)) begin
                    state_d = ST_STALL;
                    cnt_d   = CNT_W'(LOAD_LAT - 1);
                end
            end
            ST_STALL: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if (flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end
    end

    // FSM outputs and handshake
    always_comb begin
        id_stall = load_use || (state_q == ST_STALL);
        id_valid = valid_q && !id_stall;
        id_ready = rdy_q && !id_stall && (!valid_q || ex_ready);
    end

    // IF/ID register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            inst_q   <= '0;
            pc4_q    <= '0;
            rdy_q    <= 1'b0;
            served_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (flush) begin
                valid_q  <= 1'b0;
                served_q <= 1'b0;
            end else if (id_ready) begin
                valid_q  <= if_valid;
                inst_q   <= if_inst;
                pc4_q    <= if_pc4;
                served_q <= 1'b0;
            end else if (load_use) begin
                served_q <= 1'b1;
            end
        end
    end

    id_fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_sel_a (
        .addr      (rs),
        .fwd_valid (fwd_valid),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
        .rf_data   (rf_rdata_a),
        .data      (id_opa)
    );

    id_fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_sel_b (
        .addr      (rt),
        .fwd_valid (fwd_valid),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
        .rf_data   (rf_rdata_b),
        .data      (id_opb)
    );

`ifdef ID_BRANCH_COMPARE_EN
    assign id_br_eq = valid_q && !id_stall && (id_opa == id_opb);
`else
    assign id_br_eq = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_gen.sv
// tb/tb_id_stage_gen.sv - self-checking bench for id_stage_gen
module tb_id_stage_gen;

    localparam int XLEN = 32;
    localparam int NFWD = 3;
    localparam int LAT  = 2;
`ifdef ID_BRANCH_COMPARE_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic              clk, rst;
    logic              if_valid, id_ready, ex_ready, id_valid, flush;
    logic [31:0]       if_inst, id_inst;
    logic [XLEN-1:0]   if_pc4, id_pc4;
    logic [4:0]        rf_raddr_a, rf_raddr_b, ex_dest;
    logic [XLEN-1:0]   rf_rdata_a, rf_rdata_b, id_opa, id_opb;
    logic [NFWD-1:0]   fwd_valid;
    logic [5*NFWD-1:0] fwd_dest;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic              ex_is_load, id_stall, id_br_eq;

    int errors = 0;
    int checks = 0;

    id_stage_gen #(.XLEN(XLEN), .NFWD(NFWD), .LOAD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4), .id_ready(id_ready),
        .ex_ready(ex_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc4(id_pc4),
        .flush(flush), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .id_opa(id_opa), .id_opb(id_opb), .id_stall(id_stall), .id_br_eq(id_br_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs, rt;
        logic [2:0]  fv;
        logic [4:0]  d0, d1, d2;
        logic [31:0] x0, x1, x2, rfa, rfb;
        logic [31:0] ea, eb;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t);
        return {6'h23, s, t, 16'h0040};
    endfunction

    // Reference operand rule: $0 is zero, nearest matching channel wins,
    // otherwise the register file.
    function automatic logic [31:0] ref_op(input logic [4:0] a, input logic [2:0] fv,
                                           input logic [4:0] d[3], input logic [31:0] x[3],
                                           input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        for (int c = 0; c < 3; c++)
            if (fv[c] && d[c] == a) return x[c];
        return rf;
    endfunction

    // Place an instruction in IF/ID, then hold it with ex_ready low.
    task automatic load_inst(input logic [31:0] inst, input logic [31:0] pc4);
        ex_is_load = 1'b0;
        flush      = 1'b0;
        ex_ready   = 1'b1;
        if_valid   = 1'b1;
        if_inst    = inst;
        if_pc4     = pc4;
        tick();
        if_valid   = 1'b0;
        ex_ready   = 1'b0;
    endtask

    task automatic drive_fwd(input logic [2:0] fv, input logic [4:0] d[3], input logic [31:0] x[3]);
        fwd_valid = fv;
        for (int c = 0; c < 3; c++) begin
            fwd_dest[c*5 +: 5]   = d[c];
            fwd_data[c*32 +: 32] = x[c];
        end
    endtask

    initial begin
        logic [4:0]  dd[3];
        logic [31:0] xx[3];
        logic [31:0] arr[6];
        logic [31:0] rcv[$];
        logic [31:0] held, ea, eb, x_inst;
        int stall_n, issue_n, bubble_bad, k;
        logic first_stall;

        vt[0] = '{5'd5, 5'd6, 3'b011, 5'd5, 5'd5, 5'd9, 32'hAAAA, 32'hBBBB, 32'hCCCC,
                  32'h1111, 32'h2222, 32'hAAAA, 32'h2222};
        vt[1] = '{5'd0, 5'd3, 3'b001, 5'd0, 5'd1, 5'd2, 32'h1234, 32'h0, 32'h0,
                  32'h5555, 32'h2222, 32'h0, 32'h2222};
        vt[2] = '{5'd4, 5'd4, 3'b100, 5'd1, 5'd2, 5'd4, 32'h1, 32'h2, 32'h10,
                  32'h7777, 32'h8888, 32'h10, 32'h10};
        vt[3] = '{5'd8, 5'd9, 3'b111, 5'd9, 5'd9, 5'd9, 32'h1, 32'h2, 32'h3,
                  32'h4444, 32'h6666, 32'h4444, 32'h1};
        vt[4] = '{5'd7, 5'd7, 3'b000, 5'd7, 5'd7, 5'd7, 32'h9, 32'h9, 32'h9,
                  32'h3333, 32'h3334, 32'h3333, 32'h3334};
        vt[5] = '{5'd31, 5'd2, 3'b110, 5'd31, 5'd31, 5'd2, 32'hDEAD, 32'hBEEF, 32'hF00D,
                  32'h0, 32'h0, 32'hBEEF, 32'hF00D};

        rst = 1'b0; if_valid = 1'b1; if_inst = mk(5'd1, 5'd2); if_pc4 = 32'h4;
        ex_ready = 1'b1; flush = 1'b0; rf_rdata_a = '0; rf_rdata_b = '0;
        fwd_valid = '0; fwd_dest = '0; fwd_data = '0; ex_is_load = 1'b0; ex_dest = '0;

        // Reset state
        #2;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_stall", id_stall, 0);
        chk("rst_id_ready", id_ready, 0);
        chk("rst_id_br_eq", id_br_eq, 0);
        @(posedge clk); #1;
        rst = 1'b1; if_valid = 1'b0;
        chk("ready_at_release", id_ready, 0);
        tick();
        chk("ready_after_release", id_ready, 1);

        // Operand selection table
        for (int v = 0; v < 6; v++) begin
            load_inst(mk(vt[v].rs, vt[v].rt), 32'h100 + v*4);
            dd[0] = vt[v].d0; dd[1] = vt[v].d1; dd[2] = vt[v].d2;
            xx[0] = vt[v].x0; xx[1] = vt[v].x1; xx[2] = vt[v].x2;
            drive_fwd(vt[v].fv, dd, xx);
            rf_rdata_a = vt[v].rfa; rf_rdata_b = vt[v].rfb;
            #1;
            chk($sformatf("tbl%0d_raddr_a", v), rf_raddr_a, vt[v].rs);
            chk($sformatf("tbl%0d_opa", v), id_opa, vt[v].ea);
            chk($sformatf("tbl%0d_opb", v), id_opb, vt[v].eb);
            chk($sformatf("tbl%0d_br_eq", v), id_br_eq, BR_EN && (vt[v].ea == vt[v].eb));
            if (v == 0) begin
                chk("tbl_id_valid", id_valid, 1);
                chk("tbl_id_pc4", id_pc4, 32'h100);
            end
        end

        // Randomised operand selection against the reference rule
        for (int r = 0; r < 30; r++) begin
            logic [4:0] s, t;
            logic [2:0] fv;
            s = 5'($urandom_range(0, 3));
            t = 5'($urandom_range(0, 3));
            fv = 3'($urandom_range(0, 7));
            for (int c = 0; c < 3; c++) begin
                dd[c] = 5'($urandom_range(0, 3));
                xx[c] = $urandom;
            end
            load_inst(mk(s, t), 32'h200);
            drive_fwd(fv, dd, xx);
            rf_rdata_a = $urandom; rf_rdata_b = $urandom;
            #1;
            ea = ref_op(s, fv, dd, xx, rf_rdata_a);
            eb = ref_op(t, fv, dd, xx, rf_rdata_b);
            chk($sformatf("rnd%0d_opa", r), id_opa, ea);
            chk($sformatf("rnd%0d_opb", r), id_opb, eb);
        end
        fwd_valid = '0;

        // Load-use: stall exactly LAT cycles, then one issue
        x_inst = mk(5'd3, 5'd7);
        load_inst(x_inst, 32'h300);
        ex_is_load = 1'b1; ex_dest = 5'd7; ex_ready = 1'b1; if_valid = 1'b0;
        stall_n = 0; issue_n = 0; bubble_bad = 0; first_stall = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (c == 0) first_stall = id_stall;
            if (id_stall) stall_n++;
            if (id_stall && id_valid) bubble_bad++;
            if (id_valid && ex_ready && id_inst == x_inst) issue_n++;
            @(posedge clk); #1;
        end
        chk("lu_detect_cycle_stall", first_stall, 1);
        chk("lu_stall_cycles", stall_n, LAT);
        chk("lu_bubble_valid", bubble_bad, 0);
        chk("lu_issue_once", issue_n, 1);
        ex_is_load = 1'b0;

        // NOP never stalls
        load_inst(32'h0, 32'h310);
        ex_is_load = 1'b1; ex_dest = 5'd7;
        #1;
        chk("nop_no_stall", id_stall, 0);
        ex_is_load = 1'b0;
        tick();

        // Backpressure stream with scoreboard
        for (int i = 0; i < 6; i++) arr[i] = mk(5'(i + 8), 5'(i + 16)) | 32'(i);
        k = 0; held = '0;
        ex_ready = 1'b1; if_valid = 1'b0; tick();
        for (int cyc = 0; cyc < 30; cyc++) begin
            if_valid = (k < 6);
            if_inst  = (k < 6) ? arr[k] : 32'h0;
            if_pc4   = 32'(k);
            ex_ready = !(cyc >= 2 && cyc <= 4);
            #2;
            if (!ex_ready) begin
                chk($sformatf("bp_ready_low_c%0d", cyc), id_ready, 0);
                if (cyc == 2) held = id_inst;
                else chk($sformatf("bp_held_c%0d", cyc), id_inst, held);
            end
            if (id_valid && ex_ready) rcv.push_back(id_inst);
            if (id_ready && if_valid) k++;
            @(posedge clk); #1;
            if (rcv.size() == 6) break;
        end
        if_valid = 1'b0;
        chk("bp_count", rcv.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("bp_order%0d", i), (i < rcv.size()) ? rcv[i] : 32'hX, arr[i]);

        // Flush during STALL
        load_inst(mk(5'd2, 5'd7), 32'h400);
        ex_is_load = 1'b1; ex_dest = 5'd7; ex_ready = 1'b1;
        tick();
        chk("fl_in_stall", id_stall, 1);
        chk("fl_in_stall_valid", id_valid, 0);
        flush = 1'b1; if_valid = 1'b1; if_inst = mk(5'd1, 5'd1);
        tick();
        flush = 1'b0; if_valid = 1'b0;
        chk("fl_valid_cleared", id_valid, 0);
        chk("fl_stall_cleared", id_stall, 0);
        chk("fl_ready", id_ready, 1);
        ex_is_load = 1'b0;

        // Reset asserted mid-stall
        load_inst(mk(5'd7, 5'd1), 32'h500);
        ex_is_load = 1'b1; ex_dest = 5'd7; ex_ready = 1'b1;
        tick();
        chk("rs_in_stall", id_stall, 1);
        rst = 1'b0;
        #1;
        chk("rs_stall_dropped", id_stall, 0);
        chk("rs_ready_low", id_ready, 0);
        chk("rs_valid_low", id_valid, 0);
        ex_is_load = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("rs_after_stall", id_stall, 0);
        chk("rs_after_ready", id_ready, 1);
        chk("rs_after_valid", id_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
